// File: rtl/weight_pingpong_buf.sv
// Double-buffered weight store: the biu fills one bank while the MAC array reads the other.
// Optional build macro WBUF_WCNT_CHECK_EN adds a per-load write counter that must reach BANK_WORDS before done is accepted.
module weight_pingpong_buf #(
  parameter int DW         = 32,
  parameter int N_GRP      = 16,
  parameter int N_KPOS     = 9,
  parameter int BANK_WORDS = N_GRP * (N_KPOS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          weight_wen,
  input  logic [31:0]   weight_waddr,
  input  logic [DW-1:0] weight_wdata,
  input  logic          weight_done,
  output logic          wbuf_wr_rdy,
  output logic          wbuf_vld,
  output logic [7:0]    wbuf_och,
  input  logic          wbuf_rd_en,
  input  logic [3:0]    wbuf_rd_kpos,
  input  logic [3:0]    wbuf_rd_grp,
  output logic [DW-1:0] wbuf_rd_data,
  output logic          wbuf_rd_dvld,
  input  logic          wbuf_release,
  output logic          wbuf_err
);

  localparam int IW = $clog2(BANK_WORDS);
  localparam int AW = $clog2(2 * BANK_WORDS);
  localparam int ONE_BASE = N_KPOS * N_GRP;

  logic [DW-1:0] mem [2*BANK_WORDS];

  logic       wr_ptr, rd_ptr;
  logic [1:0] full, full_nxt;
  logic [7:0] tag [2];
  logic       err;

  logic          w_is_1x1;
  logic [5:0]    w_kpos;
  logic [3:0]    w_grp;
  logic          w_addr_bad;
  logic [IW-1:0] w_idx;
  logic [AW-1:0] w_maddr;
  logic          wr_acc, wr_err;

  logic          cnt_ok;
  logic          done_ok, done_err;
  logic          rel_ok;

  logic          r_kpos_bad;
  logic [IW-1:0] r_idx;
  logic [AW-1:0] r_maddr;
  logic          rd_ok, rd_err;

  // Write address decode
  assign w_is_1x1   = weight_waddr[31];
  assign w_kpos     = weight_waddr[11:6];
  assign w_grp      = weight_waddr[3:0];
  assign w_addr_bad = (weight_waddr[5:4] != 2'b00) ||
                      (!w_is_1x1 && (w_kpos >= 6'(N_KPOS)));
  assign w_idx      = w_is_1x1 ? IW'(ONE_BASE) + IW'(w_grp)
                               : IW'(w_kpos) * IW'(N_GRP) + IW'(w_grp);
  assign w_maddr    = AW'(w_idx) + (wr_ptr ? AW'(BANK_WORDS) : AW'(0));

  assign wr_acc = weight_wen && !w_addr_bad && !full[wr_ptr];
  assign wr_err = weight_wen && (w_addr_bad || full[wr_ptr]);

`ifdef WBUF_WCNT_CHECK_EN
  logic [7:0] wcnt, wcnt_inc;

  // Include a write landing in the same cycle as done so the last word counts.
  assign wcnt_inc = wcnt + 8'(wr_acc);
  assign cnt_ok   = (wcnt_inc == 8'(BANK_WORDS));

  always_ff @(posedge clk) begin
    if (!rst_n)           wcnt <= '0;
    else if (weight_done) wcnt <= '0;
    else                  wcnt <= wcnt_inc;
  end
`else
  assign cnt_ok = 1'b1;
`endif

  assign done_ok  = weight_done && !full[wr_ptr] && cnt_ok;
  assign done_err = weight_done && !done_ok;
  assign rel_ok   = wbuf_release && full[rd_ptr];

  // Read address decode
  assign r_kpos_bad = (wbuf_rd_kpos > 4'(N_KPOS));
  assign r_idx      = (wbuf_rd_kpos == 4'(N_KPOS)) ? IW'(ONE_BASE) + IW'(wbuf_rd_grp)
                                                   : IW'(wbuf_rd_kpos) * IW'(N_GRP) + IW'(wbuf_rd_grp);
  assign r_maddr    = AW'(r_idx) + (rd_ptr ? AW'(BANK_WORDS) : AW'(0));

  assign rd_ok  = wbuf_rd_en && full[rd_ptr] && !r_kpos_bad;
  assign rd_err = wbuf_rd_en && !rd_ok;

  // Done and release judge against the pre-cycle full flags, so with a shared
  // pointer at most one of them can take effect.
  always_comb begin
    full_nxt = full;
    if (done_ok) full_nxt[wr_ptr] = 1'b1;
    if (rel_ok)  full_nxt[rd_ptr] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      full   <= 2'b00;
      tag[0] <= '0;
      tag[1] <= '0;
      err    <= 1'b0;
    end else begin
      full <= full_nxt;
      if (done_ok) wr_ptr <= ~wr_ptr;
      if (rel_ok)  rd_ptr <= ~rd_ptr;
      if (wr_acc)  tag[wr_ptr] <= weight_waddr[30:23];
      if (wr_err || done_err || rd_err) err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) mem[w_maddr] <= weight_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbuf_rd_data <= '0;
      wbuf_rd_dvld <= 1'b0;
    end else begin
      wbuf_rd_dvld <= rd_ok;
      if (rd_ok) wbuf_rd_data <= mem[r_maddr];
    end
  end

  assign wbuf_wr_rdy = !full[wr_ptr];
  assign wbuf_vld    = full[rd_ptr];
  assign wbuf_och    = tag[rd_ptr];
  assign wbuf_err    = err;

endmodule

// File: tb/tb_weight_pingpong_buf.sv
// Bench for weight_pingpong_buf: bank-level reference model checked every cycle plus literal pins.
// Build with WBUF_WCNT_CHECK_EN defined to exercise the write-count variant.
module tb_weight_pingpong_buf;
  localparam int BW = 160;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        weight_wen, weight_done, wbuf_rd_en, wbuf_release;
  logic [31:0] weight_waddr, weight_wdata;
  logic [3:0]  wbuf_rd_kpos, wbuf_rd_grp;
  logic        wbuf_wr_rdy, wbuf_vld, wbuf_rd_dvld, wbuf_err;
  logic [7:0]  wbuf_och;
  logic [31:0] wbuf_rd_data;

  always #5 clk = ~clk;

  weight_pingpong_buf dut (
    .clk(clk), .rst_n(rst_n),
    .weight_wen(weight_wen), .weight_waddr(weight_waddr), .weight_wdata(weight_wdata),
    .weight_done(weight_done),
    .wbuf_wr_rdy(wbuf_wr_rdy), .wbuf_vld(wbuf_vld), .wbuf_och(wbuf_och),
    .wbuf_rd_en(wbuf_rd_en), .wbuf_rd_kpos(wbuf_rd_kpos), .wbuf_rd_grp(wbuf_rd_grp),
    .wbuf_rd_data(wbuf_rd_data), .wbuf_rd_dvld(wbuf_rd_dvld),
    .wbuf_release(wbuf_release), .wbuf_err(wbuf_err)
  );

  int n_vec = 0, n_err = 0;
  bit chk_en = 1'b0;
  int dv_cnt = 0;

  // Reference model: two banks of words, a full flag per bank, write/read bank selectors.
  logic [31:0] m_mem [2][BW];
  bit   [1:0]  m_full = 2'b00;
  bit          m_wr = 1'b0, m_rd = 1'b0;
  logic [7:0]  m_tag [2];
  bit          m_err = 1'b0, m_dvld = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  int          m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    int  idx;
    bit  f_wr, f_rd, bad, d_ok;
    if (!rst_n) begin
      m_full = 2'b00; m_wr = 1'b0; m_rd = 1'b0;
      m_tag[0] = 8'h0; m_tag[1] = 8'h0;
      m_err = 1'b0; m_dvld = 1'b0; m_rdata = 32'h0; m_cnt = 0;
    end else begin
      f_wr = m_full[m_wr];
      f_rd = m_full[m_rd];
      m_dvld = 1'b0;
      if (wbuf_rd_en) begin
        if (f_rd && int'(wbuf_rd_kpos) <= 9) begin
          idx = (int'(wbuf_rd_kpos) == 9) ? 144 + int'(wbuf_rd_grp)
                                          : int'(wbuf_rd_kpos) * 16 + int'(wbuf_rd_grp);
          m_rdata = m_mem[m_rd][idx];
          m_dvld = 1'b1;
        end else m_err = 1'b1;
      end
      if (weight_wen) begin
        bad = (weight_waddr[5:4] != 2'b00) || (!weight_waddr[31] && int'(weight_waddr[11:6]) > 8);
        if (bad || f_wr) m_err = 1'b1;
        else begin
          idx = weight_waddr[31] ? 144 + int'(weight_waddr[3:0])
                                 : int'(weight_waddr[11:6]) * 16 + int'(weight_waddr[3:0]);
          m_mem[m_wr][idx] = weight_wdata;
          m_tag[m_wr] = weight_waddr[30:23];
          m_cnt++;
        end
      end
      if (weight_done) begin
        d_ok = !f_wr;
`ifdef WBUF_WCNT_CHECK_EN
        d_ok = d_ok && (m_cnt == BW);
        m_cnt = 0;
`endif
        if (d_ok) begin
          m_full[m_wr] = 1'b1;
          m_wr = !m_wr;
        end else m_err = 1'b1;
      end
      if (wbuf_release && f_rd) begin
        m_full[m_rd] = 1'b0;
        m_rd = !m_rd;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr_rdy", wbuf_wr_rdy, !m_full[m_wr]);
      chk("vld", wbuf_vld, m_full[m_rd]);
      chk("och", wbuf_och, m_tag[m_rd]);
      chk("err", wbuf_err, m_err);
      chk("dvld", wbuf_rd_dvld, m_dvld);
      chk("rd_data", wbuf_rd_data, m_rdata);
    end
    if (wbuf_rd_dvld) dv_cnt++;
  end

  task automatic clr();
    weight_wen = 1'b0; weight_done = 1'b0; wbuf_rd_en = 1'b0; wbuf_release = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); clr(); end
  endtask

  function automatic logic [31:0] mk(input bit one, input logic [7:0] och,
                                     input logic [5:0] kpos, input logic [5:0] grp);
    return {one, och, 11'b0, kpos, grp};
  endfunction

  task automatic wr_idx(input logic [7:0] och, input int idx, input logic [31:0] d, input bit dn);
    @(negedge clk); clr();
    weight_wen = 1'b1;
    weight_waddr = (idx >= 144) ? mk(1'b1, och, 6'h3f, 6'(idx - 144))
                                : mk(1'b0, och, 6'(idx / 16), 6'(idx % 16));
    weight_wdata = d;
    weight_done = dn;
  endtask

  task automatic pulse_done();
    @(negedge clk); clr(); weight_done = 1'b1;
  endtask

  task automatic load(input logic [7:0] och, input logic [31:0] base, input int n, input bit coinc);
    for (int i = 0; i < n; i++) wr_idx(och, i, base + 32'(i), coinc && (i == n - 1));
    if (!coinc) pulse_done();
  endtask

  task automatic rd(input int kpos, input int grp);
    @(negedge clk); clr();
    wbuf_rd_en = 1'b1; wbuf_rd_kpos = 4'(kpos); wbuf_rd_grp = 4'(grp);
  endtask

  task automatic rel();
    @(negedge clk); clr(); wbuf_release = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); clr(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_wr_rdy", wbuf_wr_rdy, 1);
    chk("rst_vld", wbuf_vld, 0);
    chk("rst_och", wbuf_och, 0);
    chk("rst_rd_data", wbuf_rd_data, 0);
    chk("rst_dvld", wbuf_rd_dvld, 0);
    chk("rst_err", wbuf_err, 0);
  endtask

  task automatic first_load_and_read();
    load(8'd5, 32'd0, BW, 1'b0);
    idle(1);
    chk("s1_vld", wbuf_vld, 1);
    chk("s1_och", wbuf_och, 5);
    chk("s1_wr_rdy", wbuf_wr_rdy, 1);
    rd(3, 2);
    idle(1);
    chk("s1_rd_data", wbuf_rd_data, 50);
    chk("s1_dvld", wbuf_rd_dvld, 1);
  endtask

  initial begin
    int c0;
    clr();
    weight_waddr = '0; weight_wdata = '0; wbuf_rd_kpos = '0; wbuf_rd_grp = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk_reset_vals();
    rst_n = 1'b1;

    first_load_and_read();

    // two loads without release, then overflow write
    rel();
    load(8'd1, 32'h1000, BW, 1'b0);
    load(8'd2, 32'h2000, BW, 1'b0);
    idle(1);
    chk("s2_wr_rdy_full", wbuf_wr_rdy, 0);
    chk("s2_och_first", wbuf_och, 1);
    wr_idx(8'd2, 5, 32'hbad0bad0, 1'b0);
    idle(1);
    chk("s2_overflow_err", wbuf_err, 1);
    rel();
    idle(1);
    chk("s2_och_after_rel", wbuf_och, 2);
    chk("s2_wr_rdy_after_rel", wbuf_wr_rdy, 1);

    // last write coincident with done; read during release comes from old bank
    load(8'd3, 32'h3000, BW, 1'b1);
    idle(1);
    chk("s3_vld_both", wbuf_wr_rdy, 0);
    rd(9, 15);
    idle(1);
    chk("s3_old_bank_159", wbuf_rd_data, 32'h209f);
    @(negedge clk); clr();
    wbuf_release = 1'b1; wbuf_rd_en = 1'b1; wbuf_rd_kpos = 4'd9; wbuf_rd_grp = 4'd0;
    idle(1);
    chk("s3_rd_on_release", wbuf_rd_data, 32'h2090);
    chk("s3_och_new", wbuf_och, 3);
    rd(9, 15);
    idle(1);
    chk("s3_coinc_word159", wbuf_rd_data, 32'h309f);

    // back-to-back sweep of all indices
    c0 = dv_cnt;
    for (int i = 0; i < BW; i++) rd((i < 144) ? i / 16 : 9, i % 16);
    idle(1);
    chk("s4_dvld_count", dv_cnt - c0, BW);
    rd(10, 0);
    idle(1);
    chk("s4_bad_kpos_dvld", wbuf_rd_dvld, 0);

    do_reset();
    rd(0, 0);
    idle(1);
    chk("s4_rd_invalid_dvld", wbuf_rd_dvld, 0);
    chk("s4_rd_invalid_err", wbuf_err, 1);

    // malformed write addresses
    do_reset();
    @(negedge clk); clr();
    weight_wen = 1'b1; weight_waddr = mk(1'b0, 8'd9, 6'd0, 6'h10); weight_wdata = 32'hdead0001;
    @(negedge clk); clr();
    weight_wen = 1'b1; weight_waddr = mk(1'b0, 8'd9, 6'd12, 6'h00); weight_wdata = 32'hdead0002;
    idle(1);
    chk("s5_bad_addr_err", wbuf_err, 1);
`ifdef WBUF_WCNT_CHECK_EN
    do_reset();
    load(8'd7, 32'h7000, 100, 1'b0);
    idle(1);
    chk("s5_short_vld", wbuf_vld, 0);
    chk("s5_short_err", wbuf_err, 1);
    chk("s5_short_wr_rdy", wbuf_wr_rdy, 1);
    load(8'd7, 32'h7000, BW, 1'b0);
    idle(1);
    chk("s5_full_vld", wbuf_vld, 1);
    chk("s5_full_och", wbuf_och, 7);
    rd(0, 0);
    idle(1);
    chk("s5_full_word0", wbuf_rd_data, 32'h7000);
`else
    pulse_done();
    idle(1);
    chk("s5_empty_done_vld", wbuf_vld, 1);
    chk("s5_och_untouched", wbuf_och, 0);
    rd(0, 0);
    idle(1);
    chk("s5_word0_untouched", wbuf_rd_data, 32'h2000);
`endif

    // reset in the middle of a load
    do_reset();
    for (int i = 0; i < 70; i++) wr_idx(8'd9, i, 32'h9000 + 32'(i), 1'b0);
    @(negedge clk); clr(); rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    first_load_and_read();

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
